// File: rtl/subtractor_serial_n.sv
// Bit-serial n-bit subtractor: diff = X - Y - Bin, one bit per clock, LSB first,
// behind a start/done handshake with operands latched at the accepted start.
module subtractor_serial_n #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    input  logic         Bin,
    output logic [n-1:0] diff,
    output logic         borrow,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   x_q, x_d;
    logic [n-1:0]   y_q, y_d;
    logic [n-1:0]   res_q, res_d;
    logic [n-1:0]   diff_q, diff_d;
    logic           b_q, b_d;
    logic           borrow_q, borrow_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           bit_d;
    logic           bit_b;
    logic [n-1:0]   res_shift;

    always_comb begin
        // One full-subtractor cell applied to the current LSBs.
        bit_d = x_q[0] ^ y_q[0] ^ b_q;
        bit_b = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & b_q);

        // New bits enter at the MSB so after n shifts bit 0 sits at position 0.
        res_shift        = res_q >> 1;
        res_shift[n-1]   = bit_d;

        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        res_d    = res_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                b_d   = bit_b;
                res_d = res_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(n - 1)) begin
                    state_d  = DONE;
                    diff_d   = res_shift;
                    borrow_d = bit_b;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Start is honoured only when no operation is in flight.
        if (start && (state_q == IDLE || state_q == DONE)) begin
            state_d = RUN;
            x_d     = X;
            y_d     = Y;
            b_d     = Bin;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            b_q      <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            res_q    <= res_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_subtractor_serial_n.sv
// Scoreboard bench for subtractor_serial_n: an n=8 instance for directed/random
// cases, abort and ignored-start checks, and an n=4 instance run exhaustively back-to-back.
module tb_subtractor_serial_n;

    localparam int  T = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic       bin8 = 1'b0;
    logic [7:0] diff8;
    logic       borrow8, busy8, done8;

    logic       start4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0;
    logic       bin4 = 1'b0;
    logic [3:0] diff4;
    logic       borrow4, busy4, done4;

    subtractor_serial_n #(.n(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .X(x8), .Y(y8), .Bin(bin8),
        .diff(diff8), .borrow(borrow8), .busy(busy8), .done(done8)
    );

    subtractor_serial_n #(.n(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .X(x4), .Y(y4), .Bin(bin4),
        .diff(diff4), .borrow(borrow4), .busy(busy4), .done(done4)
    );

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
        longint     t_done;
        logic       b2b;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // Reference: plain integer subtraction; the sign of the result is the borrow.
    function automatic exp_t model(input int w, input int x, input int y, input int b,
                                   input longint t_issue, input logic b2b);
        exp_t e;
        int   r;
        r        = x - y - b;
        e.borrow = (r < 0);
        e.diff   = 8'((r + (1 << w)) % (1 << w));
        e.t_done = t_issue + longint'(w * T + 6);
        e.b2b    = b2b;
        return e;
    endfunction

    // Monitor for the n=8 instance.
    initial begin : mon8
        logic [7:0] last_d;
        logic       last_b;
        int         run;
        exp_t       e;
        last_d = '0;
        last_b = 1'b0;
        run    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_d = '0;
                last_b = 1'b0;
                run    = 0;
            end else begin
                if (busy8) begin
                    run++;
                    check("stable8_diff", diff8, last_d);
                    check("stable8_borrow", borrow8, last_b);
                end
                if (done8) begin
                    if (q8.size() == 0) begin
                        check("spurious_done8", 1, 0);
                    end else begin
                        e = q8.pop_front();
                        check("diff8", diff8, e.diff);
                        check("borrow8", borrow8, e.borrow);
                        check("latency8", longint'($time), e.t_done);
                        check("busy_len8", run, 8);
                    end
                    last_d = diff8;
                    last_b = borrow8;
                    run    = 0;
                end
            end
        end
    end

    // Monitor for the n=4 instance.
    initial begin : mon4
        longint prev_t;
        int     run;
        exp_t   e;
        prev_t = 0;
        run    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                run = 0;
            end else begin
                if (busy4) run++;
                if (done4) begin
                    if (q4.size() == 0) begin
                        check("spurious_done4", 1, 0);
                    end else begin
                        e = q4.pop_front();
                        check("diff4", diff4, e.diff);
                        check("borrow4", borrow4, e.borrow);
                        check("latency4", longint'($time), e.t_done);
                        check("busy_len4", run, 4);
                        if (e.b2b) check("spacing4", longint'($time) - prev_t, 5 * T);
                    end
                    prev_t = longint'($time);
                    run    = 0;
                end
            end
        end
    end

    task automatic wait_idle8();
        int k = 0;
        while ((busy8 || done8) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) check("timeout_idle8", 0, 1);
    endtask

    // Issue one n=8 operation from IDLE, then scramble the inputs to prove latching.
    task automatic issue8(input int x, input int y, input int b, input bit push);
        wait_idle8();
        x8     = 8'(x);
        y8     = 8'(y);
        bin8   = b[0];
        start8 = 1'b1;
        if (push) q8.push_back(model(8, x, y, b, longint'($time), 1'b0));
        @(negedge clk);
        start8 = 1'b0;
        x8     = 8'($urandom);
        y8     = 8'($urandom);
        bin8   = 1'($urandom);
    endtask

    initial begin : stim
        int dx[4] = '{8'h05, 8'h00, 8'hFF, 8'h80};
        int dy[4] = '{8'h03, 8'h01, 8'hFF, 8'h00};
        int db[4] = '{0, 0, 1, 1};
        int k;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_diff8", diff8, 0);
        check("rst_borrow8", borrow8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_diff4", diff4, 0);
        check("rst_done4", done4, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) issue8(dx[i], dy[i], db[i], 1'b1);
        for (int i = 0; i < 30; i++)
            issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 1)), 1'b1);

        // Start while busy must be ignored.
        issue8(8'h10, 8'h01, 0, 1'b1);
        repeat (2) @(negedge clk);
        x8     = 8'h00;
        y8     = 8'hFF;
        bin8   = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8();
        @(negedge clk);

        // Reset mid-RUN aborts with no done pulse.
        issue8(8'h5A, 8'h33, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("midrst_busy_before", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_diff8", diff8, 0);
        check("midrst_borrow8", borrow8, 0);
        check("midrst_busy8", busy8, 0);
        check("midrst_done8", done8, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        // n=4 exhaustive, back-to-back from DONE.
        for (int i = 0; i < 512; i++) begin
            if (i > 0) begin
                k = 0;
                while (!done4 && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 20) check("timeout_done4", 0, 1);
            end
            x4     = 4'(i >> 5);
            y4     = 4'(i >> 1);
            bin4   = 1'(i);
            start4 = 1'b1;
            q4.push_back(model(4, (i >> 5) & 15, (i >> 1) & 15, i & 1,
                               longint'($time), i > 0));
            @(negedge clk);
            start4 = 1'b0;
            x4     = 4'($urandom);
            y4     = 4'($urandom);
            bin4   = 1'($urandom);
        end

        k = 0;
        while ((q8.size() != 0 || q4.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("drain_q8", q8.size(), 0);
        check("drain_q4", q4.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
